// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, FSM encoding and
// the default watchdog limit for the TX push-port arbiter.
package uart_pkg;

  localparam int UART_DW         = 8;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Index width for an n-entry vector; a 1-entry vector still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping,
// returned both one-hot and as an index.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;
  logic             found;

  // Offsets 1..N_REQ, so the previous winner is considered last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    pos    = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO push port. A granted requester keeps
// the port until its last byte is pushed or it stays silent past the watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [UART_DW*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       full_fifo_tx,
  output logic                       push_fifo_tx,
  output logic [UART_DW-1:0]         push_data_fifo_tx,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IDX_W = idx_w(N_REQ);

  // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
  // in the same cycle; that is exactly the cycle push_fifo_tx is high. ready
  // does not depend on valid, and the requester holds data/last until taken.

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic               timeout_q, timeout_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               xfer;
  logic               own_valid;
  logic               own_last;
  logic [UART_DW-1:0] own_data;
  logic               xfer_push;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // rr_ptr doubles as the owner index while in XFER.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_ptr_q == IDX_W'(i)) begin
        own_data = req_data[i*UART_DW +: UART_DW];
      end
    end
  end

  assign xfer      = (state_q == ST_XFER);
  assign own_valid = req_valid[rr_ptr_q];
  assign own_last  = req_last[rr_ptr_q];
  assign xfer_push = xfer & own_valid & ~full_fifo_tx;

  assign push_fifo_tx      = xfer_push;
  assign push_data_fifo_tx = xfer ? own_data : '0;
  assign req_ready         = (xfer && !full_fifo_tx) ? grant_q : '0;
  assign grant             = grant_q;
  assign busy              = xfer;
  assign timeout           = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_XFER;
          grant_d  = pick_onehot;
          rr_ptr_d = pick_idx;
          wd_d     = '0;
        end
      end
      ST_XFER: begin
        if (xfer_push) begin
          wd_d = '0;
          if (own_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (!own_valid) begin
          // A full FIFO with valid held is back-pressure, not a stall.
          if (wd_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = ST_IDLE;
            grant_d   = '0;
            wd_d      = '0;
            timeout_d = 1'b1;
          end else begin
            wd_d = wd_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IDX_W'(N_REQ - 1);
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
